// File: rtl/axis_bram_adapter_cfg_master_pkg.sv
// Shared definitions for the BRAM adapter configuration master: register map,
// CTRL bit positions and the sequencing FSM encoding.
package axis_bram_adapter_cfg_master_pkg;

  localparam int unsigned RegCtrlOffset  = 0;
  localparam int unsigned RegStartOffset = 4;
  localparam int unsigned RegEndOffset   = 8;

  localparam int unsigned RwBit     = 0;
  localparam int unsigned ReloadBit = 1;

  localparam logic [1:0] LastStep = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitB,
    StDone
  } cfg_state_e;

  function automatic logic [31:0] ctrl_word(input logic rw, input logic reload);
    logic [31:0] w;
    w            = '0;
    w[RwBit]     = rw;
    w[ReloadBit] = reload;
    return w;
  endfunction

endpackage

// File: rtl/axis_bram_adapter_cfg_master_axil_single_write.sv
// Single AXI4-Lite write: owns the AW/W/B handshakes for one address/data pair.
// AW and W valids retire independently; bready is raised once both have retired.
module axis_bram_adapter_cfg_master_axil_single_write #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] data,
  output logic [AddrWidth-1:0] awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [DataWidth-1:0] wdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic                 issued,
  output logic                 done,
  output logic [1:0]           resp
);

  logic [AddrWidth-1:0] awaddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 awvalid_q, wvalid_q, bready_q;
  logic                 aw_hs, w_hs;

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;

  // True on the edge where the last outstanding AW/W handshake completes.
  assign issued = (awvalid_q | wvalid_q) & (~awvalid_q | awready) & (~wvalid_q | wready);
  assign done   = bready_q & bvalid;
  assign resp   = bresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else if (start) begin
      awaddr_q  <= addr;
      wdata_q   <= data;
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      bready_q  <= 1'b0;
    end else begin
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs) wvalid_q <= 1'b0;
      if (issued) bready_q <= 1'b1;
      else if (done) bready_q <= 1'b0;
    end
  end

  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: rtl/axis_bram_adapter_cfg_master.sv
// AXI4-Lite master that programs the BRAM adapter: START, END, CTRL(reload=1),
// CTRL(reload=0) per command, with busy/done/err status towards the sequencer.
module axis_bram_adapter_cfg_master
  import axis_bram_adapter_cfg_master_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned BRAM_ADDR_WIDTH    = 12,
  parameter int unsigned REG_CTRL_OFFSET    = RegCtrlOffset,
  parameter int unsigned REG_START_OFFSET   = RegStartOffset,
  parameter int unsigned REG_END_OFFSET     = RegEndOffset
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rw,
  input  logic [BRAM_ADDR_WIDTH-1:0]      cmd_start_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0]      cmd_end_addr,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                      m00_axi_awprot,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic                            m00_axi_arvalid,
  output logic                            m00_axi_rready
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

  cfg_state_e                 state_q;
  logic [1:0]                 step_q;
  logic                       rw_q;
  logic [BRAM_ADDR_WIDTH-1:0] start_addr_q, end_addr_q;
  logic                       cmd_ready_q, busy_q, done_q, err_q;

  logic                       accept, advance, wr_start, issued, wr_done;
  logic [1:0]                 wr_resp, sel_step;
  logic                       sel_rw;
  logic [BRAM_ADDR_WIDTH-1:0] sel_start, sel_end;
  logic [AW-1:0]              wr_addr;
  logic [DW-1:0]              wr_data;

  assign accept   = (state_q == StIdle) & cmd_ready_q & cmd_valid;
  assign advance  = (state_q == StWaitB) & wr_done & (wr_resp == 2'b00) & (step_q != LastStep);
  assign wr_start = accept | advance;

  // The write for the upcoming step is launched on the same edge that selects it,
  // so on accept the mux must look at the live command rather than the latches.
  always_comb begin
    sel_step  = accept ? 2'd0 : step_q + 2'd1;
    sel_rw    = accept ? cmd_rw : rw_q;
    sel_start = accept ? cmd_start_addr : start_addr_q;
    sel_end   = accept ? cmd_end_addr : end_addr_q;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (sel_step)
      2'd0: begin
        wr_addr = AW'(REG_START_OFFSET);
        wr_data = DW'(sel_start);
      end
      2'd1: begin
        wr_addr = AW'(REG_END_OFFSET);
        wr_data = DW'(sel_end);
      end
      2'd2: begin
        wr_addr = AW'(REG_CTRL_OFFSET);
        wr_data = DW'(ctrl_word(sel_rw, 1'b1));
      end
      2'd3: begin
        wr_addr = AW'(REG_CTRL_OFFSET);
        wr_data = DW'(ctrl_word(sel_rw, 1'b0));
      end
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q      <= StIdle;
      step_q       <= '0;
      rw_q         <= 1'b0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rw_q         <= cmd_rw;
            start_addr_q <= cmd_start_addr;
            end_addr_q   <= cmd_end_addr;
            step_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            cmd_ready_q  <= 1'b0;
            state_q      <= StIssue;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StIssue: begin
          if (issued) state_q <= StWaitB;
        end
        StWaitB: begin
          if (wr_done) begin
            if (wr_resp != 2'b00 || step_q == LastStep) begin
              err_q   <= err_q | (wr_resp != 2'b00);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              step_q  <= step_q + 2'd1;
              state_q <= StIssue;
            end
          end
        end
        StDone: begin
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_bram_adapter_cfg_master_axil_single_write #(
    .AddrWidth(AW),
    .DataWidth(DW)
  ) u_write (
    .clk    (m00_axi_aclk),
    .rst_n  (m00_axi_aresetn),
    .start  (wr_start),
    .addr   (wr_addr),
    .data   (wr_data),
    .awaddr (m00_axi_awaddr),
    .awvalid(m00_axi_awvalid),
    .awready(m00_axi_awready),
    .wdata  (m00_axi_wdata),
    .wvalid (m00_axi_wvalid),
    .wready (m00_axi_wready),
    .bresp  (m00_axi_bresp),
    .bvalid (m00_axi_bvalid),
    .bready (m00_axi_bready),
    .issued (issued),
    .done   (wr_done),
    .resp   (wr_resp)
  );

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_araddr  = '0;
  assign m00_axi_arvalid = 1'b0;
  assign m00_axi_rready  = 1'b0;

endmodule

// File: tb/tb_axis_bram_adapter_cfg_master.sv
// Randomized bench: an AXI-Lite slave with programmable ready/response delays and
// error injection, checked against the expected four-write register sequence.
module tb_axis_bram_adapter_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [11:0] cmd_start_addr, cmd_end_addr;
  logic        busy, done, err;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_bram_adapter_cfg_master dut (
    .m00_axi_aclk   (clk),
    .m00_axi_aresetn(rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rw         (cmd_rw),
    .cmd_start_addr (cmd_start_addr),
    .cmd_end_addr   (cmd_end_addr),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .m00_axi_awaddr (awaddr),
    .m00_axi_awprot (awprot),
    .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata  (wdata),
    .m00_axi_wstrb  (wstrb),
    .m00_axi_wvalid (wvalid),
    .m00_axi_wready (wready),
    .m00_axi_bresp  (bresp),
    .m00_axi_bvalid (bvalid),
    .m00_axi_bready (bready),
    .m00_axi_araddr (araddr),
    .m00_axi_arvalid(arvalid),
    .m00_axi_rready (rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One write as seen by the slave; called at a negedge, returns at a negedge.
  task automatic do_write(input int step, input logic [4:0] ea, input logic [31:0] ed,
                          input logic [1:0] rsp, input int aw_d, input int w_d, input int b_d);
    bit aw_ok, w_ok;
    int n;
    aw_ok = 0;
    w_ok  = 0;
    n     = 0;
    while (!(aw_ok && w_ok) && n < 100) begin
      if (aw_ok) check_eq($sformatf("aw_dropped%0d", step), awvalid, 0);
      else begin
        check_eq($sformatf("awvalid_held%0d", step), awvalid, 1);
        check_eq($sformatf("awaddr%0d", step), awaddr, ea);
      end
      if (w_ok) check_eq($sformatf("w_dropped%0d", step), wvalid, 0);
      else begin
        check_eq($sformatf("wvalid_held%0d", step), wvalid, 1);
        check_eq($sformatf("wdata%0d", step), wdata, ed);
      end
      awready = !aw_ok && n >= aw_d;
      wready  = !w_ok && n >= w_d;
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      @(negedge clk);
      n++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    check_eq($sformatf("aw_w_complete%0d", step), aw_ok && w_ok, 1);
    repeat (b_d) begin
      check_eq($sformatf("bready_early%0d", step), bready, 1);
      @(negedge clk);
    end
    bvalid = 1'b1;
    bresp  = rsp;
    n      = 0;
    while (!bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("bready%0d", step), bready, 1);
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  // Issues one command and checks the whole sequence; abort_step >= 0 asserts reset there.
  task automatic run_cmd(input logic rw, input logic [11:0] s, input logic [11:0] e,
                         input int err_step, input int aw_d, input int w_d, input int b_d,
                         input bit hold, input int abort_step);
    logic [4:0]  ea[4];
    logic [31:0] ed[4];
    int          n, c0, last, lat;
    ea[0] = 5'h4;  ed[0] = {20'd0, s};
    ea[1] = 5'h8;  ed[1] = {20'd0, e};
    ea[2] = 5'h0;  ed[2] = {30'd0, 1'b1, rw};
    ea[3] = 5'h0;  ed[3] = {31'd0, rw};
    last = (err_step >= 0) ? err_step : 3;
    lat  = 1 + (last + 1) * (((aw_d > w_d) ? aw_d : w_d) + 2 + b_d);

    cmd_valid      = 1'b1;
    cmd_rw         = rw;
    cmd_start_addr = s;
    cmd_end_addr   = e;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    c0 = cyc;
    @(negedge clk);
    cmd_valid      = hold;
    cmd_rw         = 1'($urandom);
    cmd_start_addr = 12'($urandom);
    cmd_end_addr   = 12'($urandom);
    check_eq("busy_after_accept", busy, 1);
    check_eq("cmd_ready_busy", cmd_ready, 0);
    check_eq("err_cleared", err, 0);

    for (int i = 0; i <= last; i++) begin
      if (i == abort_step) begin
        check_eq("abort_awvalid_pre", awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_cmd_ready", cmd_ready, 1);
        check_eq("rel_done", done, 0);
        return;
      end
      do_write(i, ea[i], ed[i], (i == err_step) ? 2'b10 : 2'b00, aw_d, w_d, b_d);
    end
    n = 0;
    while (!done && n < 20) begin
      check_eq("no_extra_aw", awvalid, 0);
      @(negedge clk);
      n++;
    end
    check_eq("done", done, 1);
    check_eq("latency", cyc - c0, lat);
    check_eq("awvalid_at_done", awvalid, 0);
    check_eq("busy_at_done", busy, 0);
    check_eq("err", err, err_step >= 0);
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("cmd_ready_idle", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw = 1'b0;
    cmd_start_addr = '0;
    cmd_end_addr = '0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("reset_cmd_ready", cmd_ready, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_awvalid", awvalid, 0);
    check_eq("reset_wvalid", wvalid, 0);
    check_eq("reset_bready", bready, 0);
    check_eq("tie_awprot", awprot, 0);
    check_eq("tie_wstrb", wstrb, 4'hf);
    check_eq("tie_read", {araddr, arvalid, rready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_cmd_ready", cmd_ready, 1);

    run_cmd(1'b1, 12'd0, 12'd8, -1, 0, 0, 0, 1'b0, -1);
    run_cmd(1'b0, 12'd0, 12'd1, -1, 0, 0, 0, 1'b0, -1);
    run_cmd(1'b1, 12'h123, 12'habc, -1, 3, 0, 0, 1'b0, -1);
    run_cmd(1'b0, 12'h010, 12'h020, -1, 0, 2, 1, 1'b0, -1);
    run_cmd(1'b1, 12'h005, 12'h3ff, 1, 0, 0, 0, 1'b0, -1);
    run_cmd(1'b0, 12'hfff, 12'h000, -1, 0, 0, 0, 1'b0, -1);
    run_cmd(1'b1, 12'h0aa, 12'h0bb, -1, 0, 0, 0, 1'b1, -1);
    run_cmd(1'b0, 12'h0cc, 12'h0dd, -1, 1, 1, 0, 1'b0, -1);

    for (int k = 0; k < 30; k++) begin
      run_cmd(1'($urandom), 12'($urandom), 12'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 1'b0, -1);
    end

    run_cmd(1'b1, 12'd5, 12'd9, -1, 0, 0, 0, 1'b0, 2);
    run_cmd(1'b1, 12'd5, 12'd9, -1, 0, 0, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
